// File: rtl/arm_mem_pkg.sv
// Shared types for the IF/MEM SRAM port arbiter: FSM states, grant owner, access type.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_MEM  = 2'd2
  } grant_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Bits needed to hold 0..wait_cycles in the wait-state counter.
  function automatic int unsigned cnt_width(input int unsigned wait_cycles);
    return $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state down-counter: load a start value, decrement per cycle, flag zero.
module mem_wait_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port SRAM between instruction fetch and load/store,
// running each granted access for a fixed number of wait states.
//
// state     | meaning
// ST_IDLE   | no access; sample requests, MEM wins over IF
// ST_ACCESS | SRAM enabled with latched address/data, counting wait states
// ST_DONE   | one-cycle ready pulse to the granted requester
module mem_port_arbiter
  import arm_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   if_req_i,
  input  logic [ADDR_W-1:0]      if_addr_i,
  input  logic                   if_abort_i,
  output logic [DATA_W-1:0]      if_rdata_o,
  output logic                   if_ready_o,
  input  logic                   mem_rd_en_i,
  input  logic                   mem_wr_en_i,
  input  logic [ADDR_W-1:0]      mem_addr_i,
  input  logic [DATA_W-1:0]      mem_wdata_i,
  output logic [DATA_W-1:0]      mem_rdata_o,
  output logic                   mem_ready_o,
  output logic                   sram_en_o,
  output logic                   sram_we_o,
  output logic [SRAM_ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0]      sram_wdata_o,
  input  logic [DATA_W-1:0]      sram_rdata_i
);

  localparam int unsigned      CNT_W    = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_e                 state_q,     state_d;
  grant_e                 grant_q,     grant_d;
  op_e                    op_q,        op_d;
  logic [SRAM_ADDR_W-1:0] addr_q,      addr_d;
  logic [DATA_W-1:0]      wdata_q,     wdata_d;
  logic                   abort_q,     abort_d;
  logic                   if_ready_q,  if_ready_d;
  logic                   mem_ready_q, mem_ready_d;
  logic [DATA_W-1:0]      if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0]      mem_rdata_q, mem_rdata_d;

  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  // Byte-lane and above-SRAM address bits are not used by a word-wide SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[ADDR_W-1:SRAM_ADDR_W+2], if_addr_i[1:0],
                              mem_addr_i[ADDR_W-1:SRAM_ADDR_W+2], mem_addr_i[1:0]};

  mem_wait_counter #(
    .WIDTH (CNT_W)
  ) u_wait_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (CNT_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    abort_d     = abort_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (mem_rd_en_i || mem_wr_en_i) begin
          grant_d  = GNT_MEM;
          op_d     = mem_wr_en_i ? OP_WRITE : OP_READ;
          addr_d   = mem_addr_i[SRAM_ADDR_W+1:2];
          wdata_d  = mem_wdata_i;
          cnt_load = 1'b1;
          state_d  = ST_ACCESS;
        end else if (if_req_i) begin
          grant_d  = GNT_IF;
          op_d     = OP_READ;
          addr_d   = if_addr_i[SRAM_ADDR_W+1:2];
          cnt_load = 1'b1;
          state_d  = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if ((grant_q == GNT_IF) && if_abort_i) begin
          abort_d = 1'b1;
        end
        if (cnt_zero) begin
          state_d = ST_DONE;
          if (grant_q == GNT_IF) begin
            if_rdata_d = sram_rdata_i;
            // An abort arriving in the final wait state must still suppress ready.
            if_ready_d = !(abort_q || if_abort_i);
          end else begin
            mem_rdata_d = (op_q == OP_WRITE) ? '0 : sram_rdata_i;
            mem_ready_d = 1'b1;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end

      ST_DONE: begin
        abort_d = 1'b0;
        grant_d = GNT_NONE;
        state_d = ST_IDLE;
      end

      default: begin
        abort_d = 1'b0;
        grant_d = GNT_NONE;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      grant_q     <= GNT_NONE;
      op_q        <= OP_READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      abort_q     <= 1'b0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      abort_q     <= abort_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign sram_en_o    = (state_q == ST_ACCESS);
  assign sram_we_o    = (state_q == ST_ACCESS) && (op_q == OP_WRITE);
  assign sram_addr_o  = addr_q;
  assign sram_wdata_o = wdata_q;
  assign if_ready_o   = if_ready_q;
  assign if_rdata_o   = if_rdata_q;
  assign mem_ready_o  = mem_ready_q;
  assign mem_rdata_o  = mem_rdata_q;

endmodule
